// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size encodings, FSM states,
// and the latched request payload.
package lsu_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic            is_store;
        logic [1:0]      size;
        logic            is_unsigned;
        logic [2:0]      offset;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
    function automatic logic [3:0] bytes_of(input logic [1:0] size);
        return 4'(4'd1 << size);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: extracts/extends a load from a doubleword and merges
// store bytes into a captured doubleword.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] wshift;
    logic [7:0]      lane_mask;
    logic [7:0]      byte_en;

    // Load: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        load_data = shifted;
        case (size)
            SZ_B: load_data = is_unsigned ? {56'd0, shifted[7:0]}
                                          : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H: load_data = is_unsigned ? {48'd0, shifted[15:0]}
                                          : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: load_data = is_unsigned ? {32'd0, shifted[31:0]}
                                          : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    // Store: replace only the addressed bytes of the captured doubleword.
    always_comb begin
        lane_mask  = 8'((16'd1 << bytes_of(size)) - 16'd1);
        byte_en    = 8'(lane_mask << offset);
        wshift     = wdata << {offset, 3'b000};
        store_data = rdata;
        for (int i = 0; i < 8; i++) begin
            if (byte_en[i]) begin
                store_data[8*i +: 8] = wshift[8*i +: 8];
            end
        end
        if (size == SZ_D) begin
            store_data = wdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Sub-doubleword load/store front end for the 64-bit data memory; one request
// in flight, sub-double stores done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t      state_q, state_d;
    lsu_req_t        req_q;
    logic [XLEN-1:0] data_q;

    logic            accept_c;
    logic [3:0]      nbytes_c;
    logic            misalign_c;
    logic            range_c;
    logic            fault_c;
    logic [XLEN-1:0] lane_rdata_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] store_data_c;

    // Request qualification; the 65-bit sum keeps huge addresses from wrapping.
    always_comb begin
        accept_c   = req_valid && req_ready;
        nbytes_c   = bytes_of(req_size);
        misalign_c = |(req_addr[2:0] & 3'(nbytes_c - 4'd1));
        range_c    = ({1'b0, req_addr} + 65'(nbytes_c)) > 65'(MEM_BYTES);
        fault_c    = misalign_c || range_c;
    end

    // In READ the lane sees the live memory word; afterwards the captured one.
    assign lane_rdata_c = (state_q == READ) ? mem_rdata : data_q;

    lsu_lane u_lane (
        .rdata       (lane_rdata_c),
        .offset      (req_q.offset),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .load_data   (load_data_c),
        .store_data  (store_data_c)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (fault_c) begin
                        state_d = RESP;
                    end else if (req_is_store && (req_size == SZ_D)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = req_q.is_store ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State decodes; reset forces IDLE so mem_write drops asynchronously.
    assign req_ready = (state_q == IDLE);
    assign mem_read  = (state_q == READ);
    assign mem_write = (state_q == WRITE);
    assign mem_wdata = (state_q == WRITE) ? store_data_c : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            data_q     <= '0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
        end else begin
            state_q    <= state_d;
            resp_valid <= (state_d == RESP);
            resp_fault <= accept_c && fault_c;
            if (accept_c) begin
                req_q.is_store    <= req_is_store;
                req_q.size        <= req_size;
                req_q.is_unsigned <= req_unsigned;
                req_q.offset      <= req_addr[2:0];
                req_q.wdata       <= req_wdata;
                mem_addr          <= {req_addr[XLEN-1:3], 3'b000};
                resp_rdata        <= '0;
            end
            if (state_q == READ) begin
                data_q <= mem_rdata;
                if (!req_q.is_store) begin
                    resp_rdata <= load_data_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 1 KiB doubleword
// memory model and per-cycle activity capture.
module tb_load_store_unit;

    localparam logic [63:0] PRE = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    logic [63:0] mem [0:127];

    int n_err    = 0;
    int n_checks = 0;

    logic [7:0]  rd_bits, wr_bits, rv_bits, flt_bits, rdy_bits;
    logic [63:0] resp_seen, resp_seen2, wdata_seen;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = (mem_addr < 64'd1024) ? mem[mem_addr[9:3]] : 64'd0;
    end

    always @(posedge clk) begin
        if (mem_write && (mem_addr < 64'd1024)) mem[mem_addr[9:3]] = mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, then record bus/response activity for cycles 1..5.
    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [63:0] a, input logic [63:0] wd);
        int n = 0;
        req_is_store = st; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_accept", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rd_bits = '0; wr_bits = '0; rv_bits = '0; flt_bits = '0;
        resp_seen = 64'hDEAD; wdata_seen = 64'hDEAD;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            rd_bits[c]  = mem_read;
            wr_bits[c]  = mem_write;
            rv_bits[c]  = resp_valid;
            flt_bits[c] = resp_valid && resp_fault;
            if (resp_valid) resp_seen = resp_rdata;
            if (mem_write)  wdata_seen = mem_wdata;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[2] = PRE;
        #2;
        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_fault", 64'(resp_fault), 64'd0);
        check("rst_mem_read",   64'(mem_read),   64'd0);
        check("rst_mem_write",  64'(mem_write),  64'd0);
        check("rst_resp_rdata", resp_rdata,      64'd0);
        check("rst_mem_addr",   mem_addr,        64'd0);
        check("rst_mem_wdata",  mem_wdata,       64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Byte loads at 0x13 (byte 0x89)
        do_req(1'b0, 2'b00, 1'b0, 64'h13, 64'd0);
        check("lb_rd_cycles",  64'(rd_bits), 64'h02);
        check("lb_wr_cycles",  64'(wr_bits), 64'h00);
        check("lb_rv_cycles",  64'(rv_bits), 64'h04);
        check("lb_data",       resp_seen,    64'hFFFF_FFFF_FFFF_FF89);
        check("lb_mem_addr",   mem_addr,     64'h10);
        do_req(1'b0, 2'b00, 1'b1, 64'h13, 64'd0);
        check("lbu_rv_cycles", 64'(rv_bits), 64'h04);
        check("lbu_data",      resp_seen,    64'h0000_0000_0000_0089);
        do_req(1'b0, 2'b01, 1'b0, 64'h10, 64'd0);
        check("lh_data",       resp_seen,    64'hFFFF_FFFF_FFFF_CDEF);

        // Half store read-modify-write, then read back
        do_req(1'b1, 2'b01, 1'b0, 64'h12, 64'hBEEF);
        check("sh_rd_cycles",  64'(rd_bits),  64'h02);
        check("sh_wr_cycles",  64'(wr_bits),  64'h04);
        check("sh_rv_cycles",  64'(rv_bits),  64'h08);
        check("sh_wdata",      wdata_seen,    64'h0123_4567_BEEF_CDEF);
        check("sh_rdata",      resp_seen,     64'd0);
        check("sh_fault",      64'(flt_bits), 64'h00);
        do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
        check("ld_after_sh",   resp_seen,     64'h0123_4567_BEEF_CDEF);
        check("ld_rv_cycles",  64'(rv_bits),  64'h04);
        mem[2] = PRE;

        // Faults and the range boundary
        do_req(1'b0, 2'b10, 1'b0, 64'h12, 64'd0);
        check("lw_mis_rv",     64'(rv_bits),  64'h02);
        check("lw_mis_fault",  64'(flt_bits), 64'h02);
        check("lw_mis_rd",     64'(rd_bits),  64'h00);
        check("lw_mis_wr",     64'(wr_bits),  64'h00);
        check("lw_mis_rdata",  resp_seen,     64'd0);
        do_req(1'b1, 2'b11, 1'b0, 64'h400, 64'h1111);
        check("sd_oor_fault",  64'(flt_bits), 64'h02);
        check("sd_oor_wr",     64'(wr_bits),  64'h00);
        do_req(1'b1, 2'b11, 1'b0, 64'h3F8, 64'hA5A5_0000_1111_2222);
        check("sd_edge_wr",    64'(wr_bits),  64'h02);
        check("sd_edge_rd",    64'(rd_bits),  64'h00);
        check("sd_edge_rv",    64'(rv_bits),  64'h04);
        check("sd_edge_fault", 64'(flt_bits), 64'h00);
        check("sd_edge_wdata", wdata_seen,    64'hA5A5_0000_1111_2222);
        check("sd_edge_mem",   mem[127],      64'hA5A5_0000_1111_2222);

        // Reset during READ of a half store
        req_is_store = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 64'h10; req_wdata = 64'hBEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmid_in_read",  64'(mem_read), 64'd1);
        reset = 1'b1;
        #1;
        check("rmid_ready",    64'(req_ready), 64'd1);
        check("rmid_rd_drop",  64'(mem_read),  64'd0);
        wr_bits = '0; rv_bits = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            wr_bits[c] = mem_write;
            rv_bits[c] = resp_valid;
        end
        check("rmid_no_write", 64'(wr_bits), 64'h00);
        check("rmid_no_resp",  64'(rv_bits), 64'h00);
        check("rmid_mem",      mem[2],       PRE);

        // Reset during WRITE: mem_write must fall without a clock edge
        req_is_store = 1'b1; req_addr = 64'h10; req_wdata = 64'hBEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        check("rwr_write_hi",  64'(mem_write), 64'd1);
        reset = 1'b1;
        #1;
        check("rwr_write_lo",  64'(mem_write), 64'd0);
        @(posedge clk); #1;
        check("rwr_mem",       mem[2],         PRE);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back lw with req_valid held high
        req_is_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 64'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 64'h14;
        rdy_bits = '0; rv_bits = '0; resp_seen = 64'hDEAD; resp_seen2 = 64'hDEAD;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rdy_bits[c] = req_ready;
            rv_bits[c]  = resp_valid;
            if (resp_valid && c <= 3) resp_seen  = resp_rdata;
            if (resp_valid && c > 3)  resp_seen2 = resp_rdata;
            if (c == 4) req_valid = 1'b0;
        end
        check("b2b_ready",     64'(rdy_bits), 64'h48);
        check("b2b_rv",        64'(rv_bits),  64'h24);
        check("b2b_first",     resp_seen,     64'hFFFF_FFFF_89AB_CDEF);
        check("b2b_second",    resp_seen2,    64'h0000_0000_0123_4567);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
